// File: rtl/rca_pkg.sv
// rca_pkg: shared constants for the ripple-carry adder slice.
//   RCA_DEFAULT_WIDTH : default operand width of ripple_carry_adder.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;

endpackage : rca_pkg

// File: rtl/ripple_carry_adder_full_adder.sv
// full_adder: one bit slice of the ripple chain.
// Ports:
//   a, b  : operand bits
//   cin   : carry from the previous slice
//   s     : sum bit
//   cout  : carry to the next slice (majority of a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: N-bit ripple-carry adder with a combinational result
// and a one-cycle registered copy qualified by in_valid.
// Ports:
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   a, b, cin      : unsigned operands and carry-in
//   in_valid       : captures the current sum/cout on the next rising clk
//   sum, cout      : combinational {cout, sum} = a + b + cin
//   sum_q, cout_q  : registered result, held while in_valid is low
//   out_valid      : in_valid delayed by one cycle
//   ovf, ovf_q     : two's-complement overflow (comb / registered), present
//                    only when RIPPLE_CARRY_ADDER_OVF_EN is defined
module ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int N = RCA_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         in_valid,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic [N-1:0] sum_q,
    output logic         cout_q,
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    output logic         ovf,
    output logic         ovf_q,
`endif
    output logic         out_valid
);

    if (N < 1) begin : g_bad_width
        $error("ripple_carry_adder: N must be at least 1");
    end

    // carry[i] is the carry into stage i; carry[N] is the final carry-out.
    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_stage
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[N];

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf = carry[N-1] ^ carry[N];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
                ovf_q  <= ovf;
`endif
            end
        end
    end

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: self-checking bench for ripple_carry_adder (N=4).
// Optional overflow checks follow RIPPLE_CARRY_ADDER_OVF_EN.
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         out_valid;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    logic         ovf;
    logic         ovf_q;
`endif

    int checks;
    int failures;

    ripple_carry_adder #(.N(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        .ovf       (ovf),
        .ovf_q     (ovf_q),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, result split into low W bits and carry.
    function automatic int ref_total(input int x, input int y, input int c);
        return x + y + c;
    endfunction

    // Reference signed overflow: true signed sum out of the W-bit range.
    function automatic bit ref_ovf(input int x, input int y, input int c);
        int sx, sy, r;
        sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        r  = sx + sy + c;
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
        #2;
        checks++;
        if ({sum_q, cout_q, out_valid} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%0h exp=0", {sum_q, cout_q, out_valid});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_exhaustive();
        int t;
        for (int x = 0; x < (1 << W); x++)
            for (int y = 0; y < (1 << W); y++)
                for (int c = 0; c < 2; c++) begin
                    a = x[W-1:0]; b = y[W-1:0]; cin = c[0];
                    #1;
                    t = ref_total(x, y, c);
                    checks++;
                    if ({cout, sum} !== t[W:0]) begin
                        failures++;
                        $display("FAIL exhaustive a=%0h b=%0h cin=%0d got=%0h exp=%0h",
                                 x, y, c, {cout, sum}, t[W:0]);
                    end
                end
    endtask

    task automatic test_wrap();
        a = 4'b1111; b = 4'b0001; cin = 1'b0; #1;
        checks++;
        if ({cout, sum} !== 5'b1_0000) begin
            failures++;
            $display("FAIL wrap_f_plus_1 got=%0h exp=10", {cout, sum});
        end
        a = 4'b1111; b = 4'b1111; cin = 1'b1; #1;
        checks++;
        if ({cout, sum} !== 5'b1_1111) begin
            failures++;
            $display("FAIL wrap_f_plus_f_plus_1 got=%0h exp=1f", {cout, sum});
        end
        a = 4'b1111; b = 4'b0000; cin = 1'b1; #1;
        checks++;
        if ({cout, sum} !== 5'b1_0000) begin
            failures++;
            $display("FAIL wrap_f_plus_0_plus_1 got=%0h exp=10", {cout, sum});
        end
    endtask

    task automatic test_register();
        a = 4'b0011; b = 4'b0101; cin = 1'b1; in_valid = 1'b1;
        step();
        checks++;
        if ({sum_q, cout_q, out_valid} !== {4'b1001, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL capture got sum_q=%0h cout_q=%0d ov=%0d exp 9/0/1",
                     sum_q, cout_q, out_valid);
        end
        in_valid = 1'b0; a = 4'b1110; b = 4'b0111;
        step();
        checks++;
        if ({sum_q, cout_q, out_valid} !== {4'b1001, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL hold got sum_q=%0h cout_q=%0d ov=%0d exp 9/0/0",
                     sum_q, cout_q, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int exp_sum, exp_cout, exp_valid, exp_ovf, t;
        int x, y, c, v;
        exp_sum = 9; exp_cout = 0; exp_valid = 0; exp_ovf = 0;
        for (int n = 0; n < 200; n++) begin
            x = int'($urandom_range(0, (1 << W) - 1));
            y = int'($urandom_range(0, (1 << W) - 1));
            c = int'($urandom_range(0, 1));
            v = (n < 20) ? 1 : int'($urandom_range(0, 3) != 0);
            a = x[W-1:0]; b = y[W-1:0]; cin = c[0]; in_valid = v[0];
            step();
            exp_valid = v;
            if (v != 0) begin
                t        = ref_total(x, y, c);
                exp_sum  = t % (1 << W);
                exp_cout = t >> W;
                exp_ovf  = int'(ref_ovf(x, y, c));
            end
            checks++;
            if ({sum_q, cout_q, out_valid} !== {exp_sum[W-1:0], exp_cout[0], exp_valid[0]}) begin
                failures++;
                $display("FAIL back_to_back n=%0d got sum_q=%0h cout_q=%0d ov=%0d exp %0h/%0d/%0d",
                         n, sum_q, cout_q, out_valid, exp_sum, exp_cout, exp_valid);
            end
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            checks++;
            if (ovf_q !== exp_ovf[0]) begin
                failures++;
                $display("FAIL ovf_q n=%0d got=%0d exp=%0d", n, ovf_q, exp_ovf);
            end
`endif
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        a = 4'b0110; b = 4'b0111; cin = 1'b0; in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || sum_q !== 4'b1101) begin
            failures++;
            $display("FAIL pre_reset_capture got ov=%0d sum_q=%0h exp 1/d", out_valid, sum_q);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_q, cout_q, out_valid} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%0h exp=0", {sum_q, cout_q, out_valid});
        end
        a = 4'b1100; b = 4'b0101; cin = 1'b1; #1;
        checks++;
        if ({cout, sum} !== 5'b1_0010) begin
            failures++;
            $display("FAIL comb_in_reset got=%0h exp=12", {cout, sum});
        end
        step();
        checks++;
        if ({sum_q, cout_q, out_valid} !== '0) begin
            failures++;
            $display("FAIL held_in_reset got=%0h exp=0", {sum_q, cout_q, out_valid});
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if ({sum_q, cout_q, out_valid} !== {4'b0010, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL first_after_release got sum_q=%0h cout_q=%0d ov=%0d exp 2/1/1",
                     sum_q, cout_q, out_valid);
        end
        in_valid = 1'b0;
        step();
    endtask

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    task automatic test_ovf();
        bit e;
        for (int x = 0; x < (1 << W); x++)
            for (int y = 0; y < (1 << W); y++)
                for (int c = 0; c < 2; c++) begin
                    a = x[W-1:0]; b = y[W-1:0]; cin = c[0];
                    #1;
                    e = ref_ovf(x, y, c);
                    checks++;
                    if (ovf !== e) begin
                        failures++;
                        $display("FAIL ovf a=%0h b=%0h cin=%0d got=%0d exp=%0d", x, y, c, ovf, e);
                    end
                end
        a = 4'b1000; b = 4'b1111; cin = 1'b0; #1;
        checks++;
        if ({ovf, sum} !== {1'b1, 4'b0111}) begin
            failures++;
            $display("FAIL ovf_neg got=%0h exp=17", {ovf, sum});
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_exhaustive();
        test_wrap();
        test_register();
        test_back_to_back();
        test_async_reset();
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ripple_carry_adder
